fu_issue_reg: RTL and testbench
===============================

# fu_issue_reg

Parametrised, registered successor of the issue-to-FU allocation stage. Takes up to ISSUE_WIDTH instructions per cycle from the RS and reads their operands from the PRF. Routes each instruction to a free ALU or multiplier lane, up to one conditional branch per cycle, and holds each lane's packet in an output register until that FU accepts it. Branch squash and branch-mask clearing apply both to incoming instructions and to packets already held in lanes.

## Interface
- ISSUE_WIDTH, 3, RS issue slots per cycle
- NUM_ALU, 3, ALU lanes (lane indices 0..NUM_ALU-1)
- NUM_MULT, 1, multiplier lanes (lane indices NUM_ALU..NUM_ALU+NUM_MULT-1)
- BR_W, `BRANCH_STACK_SIZE, branch mask / stack width
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- rs_valid  in  ISSUE_WIDTH  per-slot valid from RS
- rs_entry  in  ISSUE_WIDTH x RS_OUT_ENTRY  issued instruction packets
- slot_accept  out  ISSUE_WIDTH  combinational; slot i consumed this cycle (RS re-issues unaccepted slots)
- prf_idx  out  ISSUE_WIDTH x PRF_READIN_ENTRY  combinational source1/source2 renamed_preg per slot
- prf_value  in  ISSUE_WIDTH x PRF_READOUT_ENTRY  same-cycle operand values
- branch_recovery  in  1  mispredict; squash entries whose mask overlaps branch_stack
- branch_correct  in  1  resolved correctly; clear branch_stack bits from masks
- branch_stack  in  BR_W  one-hot resolving branch
- lane_ready  in  NUM_ALU+NUM_MULT  FU in that lane accepts its packet this cycle
- fu_in  out  (NUM_ALU+NUM_MULT) x FU_IN_ENTRY  registered lane packets (valid inside)
- br_valid  out  1  registered; a conditional branch is held in ALU lane br_lane
- br_lane  out  $clog2(NUM_ALU)  ALU lane holding the branch
- issued_cnt  out  32  count of accepted slots (wrapping)
- stall_cnt  out  32  count of cycles with ≥1 valid, un-accepted, unsquashed slot (wrapping)

## Operation
- A lane is free when its packet is invalid, or when it is valid and lane_ready is high.
- Routing is combinational and in slot order, lowest slot first. A valid slot is live when it is not squashed, i.e. it does not satisfy branch_recovery & |(branch_stack & mask).
  - Live mult slots take the lowest free mult lane.
  - Live non-mult slots take the lowest free ALU lane.
  - A live cond-branch slot is eligible only if no earlier slot in the same cycle was an accepted cond branch, and no held valid branch remains in an ALU lane that is not freed this cycle.
- slot_accept[i] = routed[i] | squashed[i]. Squashed slots are consumed and discarded. An unrouted live slot is not accepted, and later slots still route independently.
- Lane register update, per lane, priority top-down:
  - the lane receives a routed slot → capture;
  - else the lane is free → valid=0;
  - else (held) → keep the packet, with mask fix-up.
- Captured fields: every RS_OUT_ENTRY field, rs1/rs2_idx = source renamed_preg, rs1/rs2_value = prf_value of the slot, is_mult_inst. branch_mask = branch_correct ? mask & ~branch_stack : mask.
- Held packet fix-up:
  - branch_recovery with overlapping mask → valid=0;
  - branch_correct → mask &= ~branch_stack.
- branch_recovery and branch_correct are never both high. If they are, recovery wins and the mask is left unchanged.
- br_valid/br_lane track the lane holding a valid cond branch. They clear when that lane is freed or squashed.
- issued_cnt += popcount(routed). stall_cnt increments per the definition above.
- Outputs at reset: all fu_in valid=0 and packet fields 0, br_valid=0, br_lane=0, issued_cnt=0, stall_cnt=0.

## Timing
- Latency: RS slot accepted in cycle N → fu_in valid in cycle N+1.
- Throughput: one packet per lane per cycle while lane_ready stays high.
- The slot_accept → RS path and the prf_idx → prf_value → capture path are same-cycle combinational. There is no combinational path from rs_entry to fu_in.
- A lane held with lane_ready=0 keeps all fields stable except mask fix-up and squash.
- Capture into a lane whose old packet leaves the same cycle (lane_ready=1) is allowed: full back-to-back operation.
- Recovery in the same cycle as capture: squashed slots are never written, and held overlapping packets are dropped in that cycle.
- reset asserted mid-stream: all lanes invalid asynchronously, and incoming slots are ignored until reset deasserts.

## Test plan
- Defaults, 3 ALU slots valid, all lane_ready=1 → slot_accept=3'b111; next cycle fu_in[0..2] valid with the PRF values; issued_cnt=3.
- Two mult slots (0,2) plus one ALU slot, NUM_MULT=1 → slot_accept=3'b011; lane 3 holds slot 0; stall_cnt increments; slot 2 is accepted the next cycle.
- Mult lane held with lane_ready[3]=0 for 4 cycles → fu_in[3] stable; new mult slots rejected; accepted in the cycle ready rises.
- Held packet mask 4'b0110, branch_correct with stack 4'b0010 → mask becomes 4'b0100. Then branch_recovery with stack 4'b0100 → lane valid=0, br_valid cleared if this lane held the branch.
- Two cond branches in slots 0 and 1 → only slot 0 is accepted; br_valid=1, br_lane=0 next cycle.
- reset low while lanes are valid → all outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/fu_issue_reg.sv
// fu_issue_reg: issue-to-FU allocation with per-lane output registers.
// Routes up to ISSUE_WIDTH RS slots per cycle onto free ALU/multiplier lanes
// (at most one conditional branch in flight), reads operands from the PRF in the
// same cycle, and holds each lane packet until its FU accepts it. Branch squash
// and mask clearing apply to incoming slots and to held packets alike.
//
// Packet layouts (LSB first):
//   rs_entry  : opcode[OP_W] | src1[PREG_W] | src2[PREG_W] | dest[PREG_W] |
//               is_mult | is_cond_br | branch_mask[BR_W]
//   prf_idx   : src1 preg | src2 preg
//   prf_value : src1 value[XLEN] | src2 value[XLEN]
//   fu_in     : valid | rs_entry[RS_W] | rs1_idx | rs2_idx | rs1_value | rs2_value
module fu_issue_reg #(
  parameter int ISSUE_WIDTH = 3,
  parameter int NUM_ALU     = 3,
  parameter int NUM_MULT    = 1,
  parameter int BR_W        = 4,
  parameter int PREG_W      = 6,
  parameter int OP_W        = 8,
  parameter int XLEN        = 32,
  localparam int NUM_LANES  = NUM_ALU + NUM_MULT,
  localparam int RS_W       = OP_W + 3 * PREG_W + 2 + BR_W,
  localparam int PRF_IN_W   = 2 * PREG_W,
  localparam int PRF_OUT_W  = 2 * XLEN,
  localparam int FU_W       = 1 + RS_W + PRF_IN_W + PRF_OUT_W,
  localparam int BRL_W      = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [ISSUE_WIDTH-1:0]               rs_valid,
  input  logic [ISSUE_WIDTH-1:0][RS_W-1:0]     rs_entry,
  output logic [ISSUE_WIDTH-1:0]               slot_accept,
  output logic [ISSUE_WIDTH-1:0][PRF_IN_W-1:0] prf_idx,
  input  logic [ISSUE_WIDTH-1:0][PRF_OUT_W-1:0] prf_value,
  input  logic                                 branch_recovery,
  input  logic                                 branch_correct,
  input  logic [BR_W-1:0]                      branch_stack,
  input  logic [NUM_LANES-1:0]                 lane_ready,
  output logic [NUM_LANES-1:0][FU_W-1:0]       fu_in,
  output logic                                 br_valid,
  output logic [BRL_W-1:0]                     br_lane,
  output logic [31:0]                          issued_cnt,
  output logic [31:0]                          stall_cnt
);

  localparam int SLOT_W   = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
  localparam int OFF_S1   = OP_W;
  localparam int OFF_S2   = OFF_S1 + PREG_W;
  localparam int OFF_DST  = OFF_S2 + PREG_W;
  localparam int OFF_MULT = OFF_DST + PREG_W;
  localparam int OFF_BR   = OFF_MULT + 1;
  localparam int OFF_MASK = OFF_BR + 1;

  logic [NUM_LANES-1:0][FU_W-1:0] lane_q, lane_d;
  logic                           br_valid_q, br_valid_d;
  logic [BRL_W-1:0]               br_lane_q, br_lane_d;
  logic [31:0]                    issued_q, issued_d;
  logic [31:0]                    stall_q, stall_d;

  logic [NUM_LANES-1:0]               lane_free;
  logic [NUM_LANES-1:0]               held_kill;
  logic [ISSUE_WIDTH-1:0]             slot_live;
  logic [ISSUE_WIDTH-1:0]             slot_squash;
  logic [ISSUE_WIDTH-1:0]             routed;
  logic [NUM_LANES-1:0]               lane_busy;
  logic [NUM_LANES-1:0]               lane_cap;
  logic [NUM_LANES-1:0][SLOT_W-1:0]   lane_src;
  logic                               br_block;
  logic                               br_taken;
  logic [BRL_W-1:0]                   br_new_lane;
  logic [RS_W-1:0]                    cap_ent;
  logic                               mask_clear;

  function automatic logic [BR_W-1:0] pkt_mask(input logic [FU_W-1:0] p);
    return p[1 + OFF_MASK +: BR_W];
  endfunction

  function automatic logic [31:0] popcnt(input logic [ISSUE_WIDTH-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) c = c + {31'd0, v[i]};
    return c;
  endfunction

  // Recovery takes precedence: mask bits are only cleared on a clean correct.
  assign mask_clear = branch_correct & ~branch_recovery;

  // Lane status: free lanes can take a new packet; held overlapping packets die.
  always_comb begin
    lane_free = '0;
    held_kill = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_free[l] = ~lane_q[l][0] | lane_ready[l];
      held_kill[l] = lane_q[l][0] & ~lane_ready[l] & branch_recovery &
                     (|(pkt_mask(lane_q[l]) & branch_stack));
    end
  end

  // Slot classification and PRF read addresses; slots are ignored while in reset.
  always_comb begin
    slot_squash = '0;
    slot_live   = '0;
    prf_idx     = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      slot_squash[i] = rs_valid[i] & reset & branch_recovery &
                       (|(rs_entry[i][OFF_MASK +: BR_W] & branch_stack));
      slot_live[i]   = rs_valid[i] & reset & ~slot_squash[i];
      prf_idx[i]     = {rs_entry[i][OFF_S2 +: PREG_W], rs_entry[i][OFF_S1 +: PREG_W]};
    end
  end

  // In-order slot routing to the lowest free lane of the right class.
  always_comb begin
    lane_busy   = ~lane_free;
    lane_cap    = '0;
    lane_src    = '0;
    routed      = '0;
    br_taken    = 1'b0;
    br_new_lane = '0;
    // A held branch that is neither leaving nor squashed blocks new branches.
    br_block    = br_valid_q & ~lane_free[br_lane_q] & ~held_kill[br_lane_q];
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (slot_live[i]) begin
        if (rs_entry[i][OFF_MULT]) begin
          for (int l = NUM_ALU; l < NUM_LANES; l++) begin
            if (!routed[i] && !lane_busy[l]) begin
              lane_busy[l] = 1'b1;
              lane_cap[l]  = 1'b1;
              lane_src[l]  = SLOT_W'(i);
              routed[i]    = 1'b1;
            end
          end
        end else if (!(rs_entry[i][OFF_BR] && (br_taken || br_block))) begin
          for (int l = 0; l < NUM_ALU; l++) begin
            if (!routed[i] && !lane_busy[l]) begin
              lane_busy[l] = 1'b1;
              lane_cap[l]  = 1'b1;
              lane_src[l]  = SLOT_W'(i);
              routed[i]    = 1'b1;
              if (rs_entry[i][OFF_BR]) begin
                br_taken    = 1'b1;
                br_new_lane = BRL_W'(l);
              end
            end
          end
        end
      end
    end
  end

  assign slot_accept = routed | slot_squash;

  // Next lane contents: capture, else drain when free or squashed, else hold.
  always_comb begin
    lane_d  = lane_q;
    cap_ent = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_cap[l]) begin
        cap_ent = rs_entry[lane_src[l]];
        if (mask_clear) cap_ent[OFF_MASK +: BR_W] = cap_ent[OFF_MASK +: BR_W] & ~branch_stack;
        lane_d[l] = {prf_value[lane_src[l]], prf_idx[lane_src[l]], cap_ent, 1'b1};
      end else if (lane_free[l] || held_kill[l]) begin
        lane_d[l][0] = 1'b0;
      end else if (mask_clear) begin
        lane_d[l][1 + OFF_MASK +: BR_W] = pkt_mask(lane_q[l]) & ~branch_stack;
      end
    end
  end

  // Branch tracking and activity counters.
  always_comb begin
    br_valid_d = br_valid_q;
    br_lane_d  = br_lane_q;
    if (br_taken) begin
      br_valid_d = 1'b1;
      br_lane_d  = br_new_lane;
    end else if (br_valid_q && (lane_free[br_lane_q] || held_kill[br_lane_q])) begin
      br_valid_d = 1'b0;
    end
    issued_d = issued_q + popcnt(routed);
    stall_d  = stall_q + {31'd0, |(slot_live & ~routed)};
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_q     <= '0;
      br_valid_q <= 1'b0;
      br_lane_q  <= '0;
      issued_q   <= '0;
      stall_q    <= '0;
    end else begin
      lane_q     <= lane_d;
      br_valid_q <= br_valid_d;
      br_lane_q  <= br_lane_d;
      issued_q   <= issued_d;
      stall_q    <= stall_d;
    end
  end

  assign fu_in      = lane_q;
  assign br_valid   = br_valid_q;
  assign br_lane    = br_lane_q;
  assign issued_cnt = issued_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_fu_issue_reg.sv
// Directed bench for fu_issue_reg with default parameters.
module tb_fu_issue_reg;

  localparam int IW = 3;
  localparam int NL = 4;
  localparam int RS_W = 32;
  localparam int FU_W = 109;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [IW-1:0]          rs_valid;
  logic [IW-1:0][RS_W-1:0] rs_entry;
  logic [IW-1:0]          slot_accept;
  logic [IW-1:0][11:0]    prf_idx;
  logic [IW-1:0][63:0]    prf_value;
  logic                   branch_recovery;
  logic                   branch_correct;
  logic [3:0]             branch_stack;
  logic [NL-1:0]          lane_ready;
  logic [NL-1:0][FU_W-1:0] fu_in;
  logic                   br_valid;
  logic [1:0]             br_lane;
  logic [31:0]            issued_cnt;
  logic [31:0]            stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  fu_issue_reg dut (
    .clock(clock), .reset(reset), .rs_valid(rs_valid), .rs_entry(rs_entry),
    .slot_accept(slot_accept), .prf_idx(prf_idx), .prf_value(prf_value),
    .branch_recovery(branch_recovery), .branch_correct(branch_correct),
    .branch_stack(branch_stack), .lane_ready(lane_ready), .fu_in(fu_in),
    .br_valid(br_valid), .br_lane(br_lane), .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pv(input logic [5:0] p);
    return 32'hC0FF_EE00 | {26'd0, p};
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [5:0] s1, input logic [5:0] s2,
                                     input logic [5:0] dst, input logic m, input logic b, input logic [3:0] mask);
    return {mask, b, m, dst, s2, s1, op};
  endfunction

  function automatic logic [FU_W-1:0] exp_pkt(input logic [31:0] e);
    return {pv(e[19:14]), pv(e[13:8]), e[19:14], e[13:8], e, 1'b1};
  endfunction

  task automatic clear_in();
    rs_valid = '0; rs_entry = '0; prf_value = '0;
    branch_recovery = 1'b0; branch_correct = 1'b0; branch_stack = '0;
    lane_ready = '1;
  endtask

  task automatic put(input int s, input logic [31:0] e);
    rs_valid[s]  = 1'b1;
    rs_entry[s]  = e;
    prf_value[s] = {pv(e[19:14]), pv(e[13:8])};
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1'b0;
    tick(); tick();
    n_vec++; if (fu_in !== '0) begin n_err++; $display("FAIL reset_fu_in: got %h want 0", fu_in); end
    n_vec++; if ({br_valid, br_lane} !== 3'b000) begin n_err++; $display("FAIL reset_br: got %b want 000", {br_valid, br_lane}); end
    n_vec++; if (issued_cnt !== 32'd0 || stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", issued_cnt, stall_cnt); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu3();
    logic [31:0] e0, e1, e2;
    e0 = mk(8'h11, 6'd1, 6'd2, 6'd10, 1'b0, 1'b0, 4'b0000);
    e1 = mk(8'h12, 6'd3, 6'd4, 6'd11, 1'b0, 1'b0, 4'b0000);
    e2 = mk(8'h13, 6'd5, 6'd6, 6'd12, 1'b0, 1'b0, 4'b0000);
    clear_in(); put(0, e0); put(1, e1); put(2, e2);
    #1;
    n_vec++; if (slot_accept !== 3'b111) begin n_err++; $display("FAIL alu3_accept: got %b want 111", slot_accept); end
    n_vec++; if (prf_idx[1] !== {6'd4, 6'd3}) begin n_err++; $display("FAIL alu3_prf_idx: got %h want %h", prf_idx[1], {6'd4, 6'd3}); end
    tick(); clear_in();
    n_vec++; if (fu_in[0] !== exp_pkt(e0)) begin n_err++; $display("FAIL alu3_lane0: got %h want %h", fu_in[0], exp_pkt(e0)); end
    n_vec++; if (fu_in[1] !== exp_pkt(e1)) begin n_err++; $display("FAIL alu3_lane1: got %h want %h", fu_in[1], exp_pkt(e1)); end
    n_vec++; if (fu_in[2] !== exp_pkt(e2)) begin n_err++; $display("FAIL alu3_lane2: got %h want %h", fu_in[2], exp_pkt(e2)); end
    n_vec++; if (fu_in[3][0] !== 1'b0) begin n_err++; $display("FAIL alu3_lane3_valid: got %b want 0", fu_in[3][0]); end
    n_vec++; if (issued_cnt !== 32'd3) begin n_err++; $display("FAIL alu3_issued: got %0d want 3", issued_cnt); end
    tick();
  endtask

  task automatic test_mult_conflict();
    logic [31:0] m0, a1, m2;
    m0 = mk(8'h21, 6'd7, 6'd8, 6'd20, 1'b1, 1'b0, 4'b0000);
    a1 = mk(8'h22, 6'd9, 6'd10, 6'd21, 1'b0, 1'b0, 4'b0000);
    m2 = mk(8'h23, 6'd11, 6'd12, 6'd22, 1'b1, 1'b0, 4'b0000);
    clear_in(); put(0, m0); put(1, a1); put(2, m2);
    #1;
    n_vec++; if (slot_accept !== 3'b011) begin n_err++; $display("FAIL mc_accept: got %b want 011", slot_accept); end
    tick();
    n_vec++; if (fu_in[3] !== exp_pkt(m0)) begin n_err++; $display("FAIL mc_lane3: got %h want %h", fu_in[3], exp_pkt(m0)); end
    n_vec++; if (fu_in[0] !== exp_pkt(a1)) begin n_err++; $display("FAIL mc_lane0: got %h want %h", fu_in[0], exp_pkt(a1)); end
    n_vec++; if (stall_cnt !== 32'd1 || issued_cnt !== 32'd5) begin n_err++; $display("FAIL mc_cnt: got %0d/%0d want 5/1", issued_cnt, stall_cnt); end
    clear_in(); put(2, m2);
    #1;
    n_vec++; if (slot_accept !== 3'b100) begin n_err++; $display("FAIL mc_retry_accept: got %b want 100", slot_accept); end
    tick();
    n_vec++; if (fu_in[3] !== exp_pkt(m2)) begin n_err++; $display("FAIL mc_retry_lane3: got %h want %h", fu_in[3], exp_pkt(m2)); end
    n_vec++; if (fu_in[0][0] !== 1'b0) begin n_err++; $display("FAIL mc_lane0_drained: got %b want 0", fu_in[0][0]); end
    n_vec++; if (issued_cnt !== 32'd6) begin n_err++; $display("FAIL mc_issued: got %0d want 6", issued_cnt); end
    clear_in(); tick();
  endtask

  task automatic test_mult_hold();
    logic [31:0] m3, mx;
    m3 = mk(8'h31, 6'd13, 6'd14, 6'd23, 1'b1, 1'b0, 4'b0000);
    mx = mk(8'h32, 6'd15, 6'd16, 6'd24, 1'b1, 1'b0, 4'b0000);
    clear_in(); put(0, m3);
    tick();
    for (int k = 0; k < 4; k++) begin
      clear_in(); lane_ready = 4'b0111; put(0, mx);
      #1;
      n_vec++; if (slot_accept !== 3'b000) begin n_err++; $display("FAIL hold_reject[%0d]: got %b want 000", k, slot_accept); end
      tick();
      n_vec++; if (fu_in[3] !== exp_pkt(m3)) begin n_err++; $display("FAIL hold_stable[%0d]: got %h want %h", k, fu_in[3], exp_pkt(m3)); end
    end
    n_vec++; if (stall_cnt !== 32'd5) begin n_err++; $display("FAIL hold_stall: got %0d want 5", stall_cnt); end
    clear_in(); put(0, mx);
    #1;
    n_vec++; if (slot_accept !== 3'b001) begin n_err++; $display("FAIL hold_release_accept: got %b want 001", slot_accept); end
    tick();
    n_vec++; if (fu_in[3] !== exp_pkt(mx)) begin n_err++; $display("FAIL hold_release_lane3: got %h want %h", fu_in[3], exp_pkt(mx)); end
    n_vec++; if (issued_cnt !== 32'd8) begin n_err++; $display("FAIL hold_issued: got %0d want 8", issued_cnt); end
    clear_in(); tick();
  endtask

  task automatic test_mask();
    logic [31:0] bm, bm2;
    bm  = mk(8'h41, 6'd17, 6'd18, 6'd25, 1'b0, 1'b1, 4'b0110);
    bm2 = mk(8'h41, 6'd17, 6'd18, 6'd25, 1'b0, 1'b1, 4'b0100);
    clear_in(); put(0, bm);
    tick();
    n_vec++; if (fu_in[0] !== exp_pkt(bm)) begin n_err++; $display("FAIL mask_capture: got %h want %h", fu_in[0], exp_pkt(bm)); end
    n_vec++; if ({br_valid, br_lane} !== 3'b100) begin n_err++; $display("FAIL mask_br_set: got %b want 100", {br_valid, br_lane}); end
    clear_in(); lane_ready = 4'b1110; branch_correct = 1'b1; branch_stack = 4'b0010;
    tick();
    n_vec++; if (fu_in[0] !== exp_pkt(bm2)) begin n_err++; $display("FAIL mask_correct: got %h want %h", fu_in[0], exp_pkt(bm2)); end
    n_vec++; if (br_valid !== 1'b1) begin n_err++; $display("FAIL mask_br_kept: got %b want 1", br_valid); end
    clear_in(); lane_ready = 4'b1110; branch_recovery = 1'b1; branch_stack = 4'b0100;
    tick();
    n_vec++; if (fu_in[0][0] !== 1'b0) begin n_err++; $display("FAIL mask_recover_valid: got %b want 0", fu_in[0][0]); end
    n_vec++; if (br_valid !== 1'b0) begin n_err++; $display("FAIL mask_recover_br: got %b want 0", br_valid); end
    clear_in(); tick();
  endtask

  task automatic test_branch_pair();
    logic [31:0] b0, b1;
    b0 = mk(8'h51, 6'd19, 6'd20, 6'd26, 1'b0, 1'b1, 4'b0000);
    b1 = mk(8'h52, 6'd21, 6'd22, 6'd27, 1'b0, 1'b1, 4'b0000);
    clear_in(); put(0, b0); put(1, b1);
    #1;
    n_vec++; if (slot_accept !== 3'b001) begin n_err++; $display("FAIL brp_accept: got %b want 001", slot_accept); end
    tick();
    n_vec++; if ({br_valid, br_lane} !== 3'b100) begin n_err++; $display("FAIL brp_br: got %b want 100", {br_valid, br_lane}); end
    n_vec++; if (fu_in[0] !== exp_pkt(b0)) begin n_err++; $display("FAIL brp_lane0: got %h want %h", fu_in[0], exp_pkt(b0)); end
    n_vec++; if (fu_in[1][0] !== 1'b0) begin n_err++; $display("FAIL brp_lane1_valid: got %b want 0", fu_in[1][0]); end
    clear_in(); lane_ready = 4'b1110; put(0, b1);
    #1;
    n_vec++; if (slot_accept !== 3'b000) begin n_err++; $display("FAIL brp_blocked: got %b want 000", slot_accept); end
    tick();
    n_vec++; if (issued_cnt !== 32'd10 || stall_cnt !== 32'd7) begin n_err++; $display("FAIL brp_cnt: got %0d/%0d want 10/7", issued_cnt, stall_cnt); end
    clear_in(); tick();
    n_vec++; if (br_valid !== 1'b0) begin n_err++; $display("FAIL brp_br_drained: got %b want 0", br_valid); end
  endtask

  task automatic test_squash_in();
    logic [31:0] s0, s1;
    s0 = mk(8'h61, 6'd23, 6'd24, 6'd28, 1'b0, 1'b0, 4'b0001);
    s1 = mk(8'h62, 6'd25, 6'd26, 6'd29, 1'b0, 1'b0, 4'b0010);
    clear_in(); branch_recovery = 1'b1; branch_stack = 4'b0001; put(0, s0); put(1, s1);
    #1;
    n_vec++; if (slot_accept !== 3'b011) begin n_err++; $display("FAIL sq_accept: got %b want 011", slot_accept); end
    tick(); clear_in();
    n_vec++; if (fu_in[0] !== exp_pkt(s1)) begin n_err++; $display("FAIL sq_lane0: got %h want %h", fu_in[0], exp_pkt(s1)); end
    n_vec++; if (fu_in[1][0] !== 1'b0) begin n_err++; $display("FAIL sq_lane1_valid: got %b want 0", fu_in[1][0]); end
    n_vec++; if (issued_cnt !== 32'd11) begin n_err++; $display("FAIL sq_issued: got %0d want 11", issued_cnt); end
    tick();
  endtask

  task automatic test_async_reset();
    logic [31:0] r0, r1;
    r0 = mk(8'h71, 6'd27, 6'd28, 6'd30, 1'b0, 1'b0, 4'b0000);
    r1 = mk(8'h72, 6'd29, 6'd30, 6'd31, 1'b0, 1'b1, 4'b0000);
    clear_in(); put(0, r0); put(1, r1);
    tick();
    clear_in(); lane_ready = 4'b0000;
    n_vec++; if (issued_cnt !== 32'd13 || br_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre: got %0d/%b want 13/1", issued_cnt, br_valid); end
    #2;
    reset = 1'b0; put(0, r0); put(1, r1);
    #1;
    n_vec++; if (fu_in !== '0) begin n_err++; $display("FAIL ar_fu_in: got %h want 0", fu_in); end
    n_vec++; if ({br_valid, br_lane} !== 3'b000 || issued_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      n_err++; $display("FAIL ar_state: got br=%b cnt=%0d/%0d want 0, 0/0", {br_valid, br_lane}, issued_cnt, stall_cnt);
    end
    n_vec++; if (slot_accept !== 3'b000) begin n_err++; $display("FAIL ar_accept: got %b want 000", slot_accept); end
    tick();
    n_vec++; if (fu_in !== '0) begin n_err++; $display("FAIL ar_held: got %h want 0", fu_in); end
    reset = 1'b1; clear_in();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu3();
    test_mult_conflict();
    test_mult_hold();
    test_mask();
    test_branch_pair();
    test_squash_in();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
